// File: rtl/seq_detect_moore_param.sv
// -----------------------------------------------------------------------------
// seq_detect_moore_param
//   Parametrised Moore serial-pattern detector. One bit is accepted on each
//   clock edge with din_valid=1. The FSM state is the number of pattern bits
//   currently matched (KMP failure automaton). The pattern is fixed when the
//   design is elaborated.
//
//   Parameters
//     PAT_LEN   pattern length, 1..16
//     PATTERN   pattern bits; PATTERN[PAT_LEN-1] is the first bit received
//     CNT_W     width of the saturating match counter
//
//   Ports
//     clk        rising-edge clock
//     rst        asynchronous active-high reset
//     din        serial data bit
//     din_valid  qualifies din; with din_valid=0 the FSM holds
//     overlap    1: overlapping detection, 0: restart after a full match
//     clr_cnt    synchronous clear of match_cnt
//     y          high while state == PAT_LEN
//     hit        one-cycle pulse after each accepted edge that reaches S[PAT_LEN]
//     match_cnt  saturating count of hits
//     state      current matched-prefix length
// -----------------------------------------------------------------------------
module seq_detect_moore_param #(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1100,
    parameter int                 CNT_W   = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         din,
    input  logic                         din_valid,
    input  logic                         overlap,
    input  logic                         clr_cnt,
    output logic                         y,
    output logic                         hit,
    output logic [CNT_W-1:0]             match_cnt,
    output logic [$clog2(PAT_LEN+1)-1:0] state
);

    localparam int SW = $clog2(PAT_LEN + 1);
    localparam logic [SW-1:0] FULL = SW'(PAT_LEN);

    generate
        if (PAT_LEN < 1 || PAT_LEN > 16) begin : g_bad_pat_len
            $error("seq_detect_moore_param: PAT_LEN must be in 1..16");
        end
    endgenerate

    // Next state from Sk on input bit b: the longest j such that the first j
    // pattern bits equal the last j bits of (first k pattern bits, then b).
    // Scanning j upwards and keeping the last match yields the longest one.
    function automatic logic [SW-1:0] kmp_next(input int k, input logic b);
        int  max_j;
        int  idx;
        logic ok;
        logic hb;
        logic [SW-1:0] res;
        res   = '0;
        max_j = (k + 1 > PAT_LEN) ? PAT_LEN : k + 1;
        for (int j = 1; j <= max_j; j++) begin
            ok = 1'b1;
            for (int m = 0; m < j; m++) begin
                idx = k + 1 - j + m;
                if (idx == k) begin
                    hb = b;
                end else begin
                    hb = PATTERN[PAT_LEN-1-idx];
                end
                if (hb != PATTERN[PAT_LEN-1-m]) begin
                    ok = 1'b0;
                end
            end
            if (ok) begin
                res = SW'(j);
            end
        end
        return res;
    endfunction

    // Constant transition tables, one entry per state and input bit value.
    logic [SW-1:0] kmp_tab0 [PAT_LEN+1];
    logic [SW-1:0] kmp_tab1 [PAT_LEN+1];

    genvar gi;
    generate
        for (gi = 0; gi <= PAT_LEN; gi++) begin : g_tab
            assign kmp_tab0[gi] = kmp_next(gi, 1'b0);
            assign kmp_tab1[gi] = kmp_next(gi, 1'b1);
        end
    endgenerate

    logic [SW-1:0]    state_reg;
    logic [SW-1:0]    state_next;
    logic             y_reg;
    logic             hit_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             full_next;
    logic             hit_next;

    always_comb begin
        state_next = '0;
        if (state_reg == FULL && !overlap) begin
            // Non-overlapping: the completed match is discarded, only din counts.
            state_next = (din == PATTERN[PAT_LEN-1]) ? SW'(1) : '0;
        end else if (din) begin
            state_next = kmp_tab1[state_reg];
        end else begin
            state_next = kmp_tab0[state_reg];
        end
    end

    assign full_next = (state_next == FULL);
    assign hit_next  = din_valid && full_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= '0;
            y_reg     <= 1'b0;
            hit_reg   <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            hit_reg <= hit_next;
            if (din_valid) begin
                state_reg <= state_next;
                // y tracks the registered state exactly (Moore decode of S[PAT_LEN]).
                y_reg     <= full_next;
            end
            // A clear coinciding with a hit keeps that hit in the count.
            if (clr_cnt) begin
                cnt_reg <= hit_next ? CNT_W'(1) : '0;
            end else if (hit_next && cnt_reg != {CNT_W{1'b1}}) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign state     = state_reg;
    assign y         = y_reg;
    assign hit       = hit_reg;
    assign match_cnt = cnt_reg;

endmodule

// File: tb/tb_seq_detect_moore_param.sv
// -----------------------------------------------------------------------------
// tb_seq_detect_moore_param
//   Directed bench for seq_detect_moore_param. Three instances share stimulus:
//     dut_a : defaults (1100, CNT_W=8)
//     dut_b : PATTERN=1010
//     dut_c : 1100 with CNT_W=2 (saturation)
//   Each step drives inputs, waits for the rising edge, then samples 1 ns later.
// -----------------------------------------------------------------------------
module tb_seq_detect_moore_param;

    logic clk = 1'b0;
    logic rst;
    logic din;
    logic din_valid;
    logic overlap;
    logic clr_cnt;

    logic       y_a, hit_a;
    logic [7:0] cnt_a;
    logic [2:0] state_a;
    logic       y_b, hit_b;
    logic [7:0] cnt_b;
    logic [2:0] state_b;
    logic       y_c, hit_c;
    logic [1:0] cnt_c;
    logic [2:0] state_c;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seq_detect_moore_param dut_a (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .overlap(overlap), .clr_cnt(clr_cnt),
        .y(y_a), .hit(hit_a), .match_cnt(cnt_a), .state(state_a)
    );

    seq_detect_moore_param #(.PAT_LEN(4), .PATTERN(4'b1010), .CNT_W(8)) dut_b (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .overlap(overlap), .clr_cnt(clr_cnt),
        .y(y_b), .hit(hit_b), .match_cnt(cnt_b), .state(state_b)
    );

    seq_detect_moore_param #(.PAT_LEN(4), .PATTERN(4'b1100), .CNT_W(2)) dut_c (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .overlap(overlap), .clr_cnt(clr_cnt),
        .y(y_c), .hit(hit_c), .match_cnt(cnt_c), .state(state_c)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic b);
        din_valid = v;
        din       = b;
        @(posedge clk);
        #1;
        $display("t=%0t step valid=%0b din=%0b ovl=%0b clr=%0b | a: st=%0d y=%0b hit=%0b cnt=%0d | b: st=%0d cnt=%0d | c: st=%0d cnt=%0d",
                 $time, v, b, overlap, clr_cnt, state_a, y_a, hit_a, cnt_a, state_b, cnt_b, state_c, cnt_c);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        din_valid = 1'b0;
        din       = 1'b0;
        clr_cnt   = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        overlap   = 1'b0;
        clr_cnt   = 1'b0;
        din       = 1'b0;
        din_valid = 1'b0;
        rst       = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", 32'(state_a), 32'd0);
        chk("reset_y",     32'(y_a),     32'd0);
        chk("reset_hit",   32'(hit_a),   32'd0);
        chk("reset_cnt",   32'(cnt_a),   32'd0);
        rst = 1'b0;

        // Test 1: 1100, overlap=0
        step(1, 1); chk("t1_st1", 32'(state_a), 32'd1);
        step(1, 1); chk("t1_st2", 32'(state_a), 32'd2);
        step(1, 0); chk("t1_st3", 32'(state_a), 32'd3);
                    chk("t1_y_early", 32'(y_a), 32'd0);
        step(1, 0); chk("t1_st4", 32'(state_a), 32'd4);
                    chk("t1_y",   32'(y_a),   32'd1);
                    chk("t1_hit", 32'(hit_a), 32'd1);
                    chk("t1_cnt", 32'(cnt_a), 32'd1);
        step(0, 0); chk("t1_hold_y",   32'(y_a),     32'd1);
                    chk("t1_hold_hit", 32'(hit_a),   32'd0);
                    chk("t1_hold_st",  32'(state_a), 32'd4);

        // Test 2: 1,1,1,0,0 -> 1,2,2,3,4 then 1 -> S1
        do_reset();
        step(1, 1); chk("t2_st_a", 32'(state_a), 32'd1); chk("t2_hit_a", 32'(hit_a), 32'd0);
        step(1, 1); chk("t2_st_b", 32'(state_a), 32'd2);
        step(1, 1); chk("t2_st_c", 32'(state_a), 32'd2); chk("t2_hit_c", 32'(hit_a), 32'd0);
        step(1, 0); chk("t2_st_d", 32'(state_a), 32'd3);
        step(1, 0); chk("t2_st_e", 32'(state_a), 32'd4); chk("t2_hit_e", 32'(hit_a), 32'd1);
                    chk("t2_cnt",  32'(cnt_a),   32'd1);
        step(1, 1); chk("t2_restart_st", 32'(state_a), 32'd1);
                    chk("t2_restart_y",  32'(y_a),     32'd0);
                    chk("t2_restart_hit", 32'(hit_a),  32'd0);

        // Test 3a: 1010 overlapping, 1,0,1,0,1,0
        do_reset();
        overlap = 1'b1;
        step(1, 1); step(1, 0); step(1, 1);
        chk("t3o_st3", 32'(state_b), 32'd3);
        step(1, 0); chk("t3o_hit1", 32'(hit_b), 32'd1);
        step(1, 1); chk("t3o_kmp",  32'(state_b), 32'd3);
                    chk("t3o_hit_gap", 32'(hit_b), 32'd0);
        step(1, 0); chk("t3o_hit2", 32'(hit_b), 32'd1);
                    chk("t3o_st",   32'(state_b), 32'd4);
                    chk("t3o_cnt",  32'(cnt_b),   32'd2);

        // Test 3b: 1010 non-overlapping
        do_reset();
        overlap = 1'b0;
        step(1, 1); step(1, 0); step(1, 1); step(1, 0);
        chk("t3n_hit1", 32'(hit_b), 32'd1);
        step(1, 1); chk("t3n_st1", 32'(state_b), 32'd1);
        step(1, 0); chk("t3n_st",  32'(state_b), 32'd2);
                    chk("t3n_hit", 32'(hit_b),   32'd0);
                    chk("t3n_cnt", 32'(cnt_b),   32'd1);

        // Test 4: hold with din_valid=0
        do_reset();
        step(1, 1); step(1, 1); step(1, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 0);
            chk("t4_hold_st",  32'(state_a), 32'd3);
            chk("t4_hold_hit", 32'(hit_a),   32'd0);
        end
        step(1, 0); chk("t4_match_st", 32'(state_a), 32'd4);
                    chk("t4_match_y",  32'(y_a),     32'd1);
                    chk("t4_cnt",      32'(cnt_a),   32'd1);

        // Test 5: async reset mid-pattern (continues from S4, cnt=1)
        step(1, 1); step(1, 1); step(1, 0);
        chk("t5_pre_st", 32'(state_a), 32'd3);
        @(negedge clk);
        rst = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        chk("t5_async_st",  32'(state_a), 32'd0);
        chk("t5_async_y",   32'(y_a),     32'd0);
        chk("t5_async_cnt", 32'(cnt_a),   32'd0);
        step(1, 0); chk("t5_after_st", 32'(state_a), 32'd0);
                    chk("t5_after_hit", 32'(hit_a), 32'd0);

        // Test 6: CNT_W=2 saturation, then clear together with a hit
        do_reset();
        for (int n = 1; n <= 5; n++) begin
            step(1, 1); step(1, 1); step(1, 0); step(1, 0);
            chk("t6_hit", 32'(hit_c), 32'd1);
            chk("t6_cnt", 32'(cnt_c), (n > 3) ? 32'd3 : 32'(n));
        end
        step(1, 1); step(1, 1); step(1, 0);
        clr_cnt = 1'b1;
        step(1, 0);
        clr_cnt = 1'b0;
        chk("t6_clr_with_hit", 32'(cnt_c), 32'd1);
        chk("t6_clr_hit",      32'(hit_c), 32'd1);
        clr_cnt = 1'b1;
        step(0, 0);
        clr_cnt = 1'b0;
        chk("t6_clr_alone",    32'(cnt_c),   32'd0);
        chk("t6_clr_keeps_st", 32'(state_c), 32'd4);
        chk("t6_clr_keeps_y",  32'(y_c),     32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
